serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial unsigned subtractor: computes A - B one bit per clock, LSB first, using one full-subtractor cell and a borrow flop.
//  Counterpart of the combinational ripple-carry adders; used where area matters more than latency.
//  Sits between a producer (valid/ready operand port) and a consumer (valid/ready result port).
// PARAMETERS
//  WIDTH   4   operand/result width in bits (>=2)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands a, b present
//  in_ready   out  1      block accepts operands (high only in IDLE)
//  a          in   WIDTH  minuend, unsigned
//  b          in   WIDTH  subtrahend, unsigned
//  out_valid  out  1      diff/borrow valid (high only in DONE)
//  out_ready  in   1      consumer takes result
//  diff       out  WIDTH  (a - b) mod 2^WIDTH (see CONFIGURATION)
//  borrow     out  1      1 when a < b
//  busy       out  1      high in SHIFT
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high. All state flops clear on rst assertion, no clock needed.
//  - Reset values: state=IDLE, in_ready=1, out_valid=0, diff=0, borrow=0, busy=0, bit counter=0.
//  - FSM: IDLE -> SHIFT on in_valid&in_ready (accept edge): latch a, b; borrow flop=0; counter=0.
//    SHIFT: each cycle bit i=counter: d=a[i]^b[i]^bin; bout=(~a[i]&b[i])|(~(a[i]^b[i])&bin);
//    d shifted into result MSB (result shifts right); bin<=bout; counter++.
//    SHIFT -> DONE after WIDTH shift cycles (counter==WIDTH-1 processed). DONE: out_valid=1.
//    DONE -> IDLE on out_valid&out_ready.
//  - Latency: out_valid rises exactly WIDTH+1 edges after the accept edge (WIDTH shift edges + one DONE-entry edge).
//  - Throughput: one operation per WIDTH+3 cycles minimum; no accept in the same cycle as the result handshake.
//  - in_ready is a combinational decode of state==IDLE; a, b, in_valid ignored outside IDLE.
//  - diff/borrow held stable through DONE regardless of out_ready; backpressure may last indefinitely.
//  - diff/borrow update only on DONE entry; intermediate shift register not visible on ports.
//  - Boundaries: a==b -> diff=0, borrow=0; a=0,b=2^WIDTH-1 -> diff=1, borrow=1; counter wraps to 0 on DONE entry.
//  - rst mid-SHIFT or mid-DONE: operation discarded, result never presented, block returns to IDLE.
// CONFIGURATION
//  SERIAL_SUB_SAT_EN defined: on DONE entry, if final borrow=1, diff is forced to 0 (saturating subtract); borrow still reported 1.
//  Undefined: diff is the wrapped two's-complement result (a - b) mod 2^WIDTH.
// STRUCTURE
//  - serial_sub_pkg: typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t; localparam default WIDTH=4.
//  - Sub-module full_subtractor (a, b, bin -> d, bout): single combinational cell instantiated once.
//  - Counter width $clog2(WIDTH); operand registers shift right so bit 0 is always the active bit.
// TESTING
//  1) WIDTH=4, a=4'b1001 b=4'b1100, out_ready=1 -> diff=4'b1101 borrow=1 (SAT_EN: diff=4'b0000), out_valid at accept+5.
//  2) a=4'b1100 b=4'b1001 -> diff=4'b0011 borrow=0; a=4'b0000 b=4'b0000 -> diff=0 borrow=0.
//  3) out_ready held 0 for 6 cycles in DONE -> out_valid, diff, borrow stable; in_ready=0; new in_valid ignored.
//  4) rst pulsed in 2nd SHIFT cycle -> outputs at reset values immediately; next op 4'b0111-4'b0010 -> diff=4'b0101 borrow=0.
//  5) in_valid held high with changing a/b -> only operands present in IDLE cycles accepted; results match each accepted pair.
//  6) WIDTH=8, a=8'h00 b=8'h01 -> diff=8'hFF borrow=1 (SAT_EN: 8'h00), out_valid at accept+9.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout set when that underflows.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B one bit per clock, LSB first.
// Optional macro SERIAL_SUB_SAT_EN: clamp diff to 0 when the result borrows.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_t       state, state_next;
    logic [CW-1:0]    cnt;
    logic             drained;   // all WIDTH bits processed, DONE entry pending
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             bin;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             d_bit, bout_bit;

    // The single cell always works on bit 0 of the right-shifting operands.
    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bin),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode: accept in IDLE, leave SHIFT once drained, release on handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = SHIFT;
            SHIFT:   if (drained)   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Datapath: latch operands, shift one bit per cycle, publish result on DONE entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            drained  <= 1'b0;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            bin      <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        res_sr  <= '0;
                        bin     <= 1'b0;
                        cnt     <= '0;
                        drained <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!drained) begin
                        a_sr   <= a_sr >> 1;
                        b_sr   <= b_sr >> 1;
                        res_sr <= {d_bit, res_sr[WIDTH-1:1]};
                        bin    <= bout_bit;
                        if (cnt == LAST) drained <= 1'b1;
                        else             cnt     <= cnt + CW'(1);
                    end else begin
                        cnt      <= '0;
                        drained  <= 1'b0;
                        borrow_q <= bin;
`ifdef SERIAL_SUB_SAT_EN
                        diff_q   <= bin ? '0 : res_sr;
`else
                        diff_q   <= res_sr;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == SHIFT);
    assign diff      = diff_q;
    assign borrow    = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: cycle-level model plus literal checks.
module tb_serial_subtractor;

    localparam int W  = 4;
    localparam int W8 = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, out_ready = 1'b1;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, borrow, busy;
    logic [W-1:0] diff;

    logic          in_valid8 = 1'b0;
    logic [W8-1:0] a8 = '0, b8 = '0;
    logic          in_ready8, out_valid8, borrow8, busy8;
    logic [W8-1:0] diff8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow), .busy(busy)
    );

    serial_subtractor #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(1'b1),
        .diff(diff8), .borrow(borrow8), .busy(busy8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an operation occupies WIDTH+1 cycles after acceptance, then
    // its arithmetic result is presented until the consumer takes it.
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_diff = '0, p_diff = '0;
    logic         m_borrow = 1'b0, p_borrow = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0; m_done = 1'b0; m_diff = '0; m_borrow = 1'b0;
        end else if (m_left == 0 && !m_done) begin
            if (in_valid) begin
                p_borrow = (a < b);
`ifdef SERIAL_SUB_SAT_EN
                p_diff = (a < b) ? '0 : W'(a - b);
`else
                p_diff = W'(a - b);
`endif
                m_left = W + 1;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1; m_diff = p_diff; m_borrow = p_borrow;
            end
        end else if (out_ready) begin
            m_done = 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("in_ready",  in_ready,  (m_left == 0 && !m_done));
        chk("busy",      busy,      (m_left > 0));
        chk("out_valid", out_valid, m_done);
        chk("diff",      diff,      m_diff);
        chk("borrow",    borrow,    m_borrow);
    end

    // Issue one op on the 4-bit DUT and check result and latency against literals.
    task automatic op4(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ed, input logic eb);
        int k, lat;
        k = 0;
        while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
        a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("op4_latency", lat, W + 1);
        chk("op4_diff",    diff, ed);
        chk("op4_borrow",  borrow, eb);
    endtask

    initial begin
        int lat;
        logic [W-1:0] ed;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1); chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0); chk("rst_borrow", borrow, 0); chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases with hand-computed results.
`ifdef SERIAL_SUB_SAT_EN
        op4(4'b1001, 4'b1100, 4'b0000, 1'b1);
        op4(4'b0000, 4'b1111, 4'b0000, 1'b1);
`else
        op4(4'b1001, 4'b1100, 4'b1101, 1'b1);
        op4(4'b0000, 4'b1111, 4'b0001, 1'b1);
`endif
        op4(4'b1100, 4'b1001, 4'b0011, 1'b0);
        op4(4'b0000, 4'b0000, 4'b0000, 1'b0);
        op4(4'b1010, 4'b1010, 4'b0000, 1'b0);

        // Backpressure: result held, new operands ignored.
        @(posedge clk); #1;
        out_ready = 1'b0;
        op4(4'b1110, 4'b0011, 4'b1011, 1'b0);
        a = 4'h3; b = 4'h1; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1); chk("bp_in_ready", in_ready, 0);
            chk("bp_diff", diff, 4'b1011);     chk("bp_borrow", borrow, 0);
            a = a + 4'h1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset in the second SHIFT cycle discards the operation.
        op4(4'b1111, 4'b0001, 4'b1110, 1'b0);
        @(posedge clk); #1;
        a = 4'b1101; b = 4'b0100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("arst_in_ready", in_ready, 1); chk("arst_busy", busy, 0);
        chk("arst_out_valid", out_valid, 0); chk("arst_diff", diff, 0);
        chk("arst_borrow", borrow, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        op4(4'b0111, 4'b0010, 4'b0101, 1'b0);

        // in_valid held high with operands changing every cycle.
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 80; i++) begin
            a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
        end
        // Fully random traffic including backpressure.
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        // 8-bit instance: 0x00 - 0x01.
        a8 = 8'h00; b8 = 8'h01; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("w8_latency", lat, W8 + 1);
`ifdef SERIAL_SUB_SAT_EN
        chk("w8_diff", diff8, 8'h00);
`else
        chk("w8_diff", diff8, 8'hFF);
`endif
        chk("w8_borrow", borrow8, 1);
        ed = '0;
        chk("w8_busy_after", {ed, busy8}, 0);

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
